// File: rtl/lifo_arb_pkg.sv
// rtl/lifo_arb_pkg.sv - shared types and helpers for the lifo client arbiter
package lifo_arb_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        FLUSH = 1'b1
    } arb_state_t;

    // A single client still needs a 1-bit index.
    function automatic int client_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first request at or after a pointer
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_any
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!gnt_any && req[idx]) begin
                gnt_any      = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = W'(idx);
            end
        end
    end

endmodule

// File: rtl/lifo_client_arbiter.sv
// rtl/lifo_client_arbiter.sv - shares one lifo among N clients, one op per cycle
module lifo_client_arbiter
    import lifo_arb_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int DWIDTH    = 16,
    parameter int AWIDTH    = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [N_CLIENTS-1:0]          push_valid_i,
    input  logic [N_CLIENTS*DWIDTH-1:0]   push_data_i,
    output logic [N_CLIENTS-1:0]          push_ready_o,
    input  logic [N_CLIENTS-1:0]          pop_valid_i,
    output logic [N_CLIENTS-1:0]          pop_ready_o,
    output logic [DWIDTH-1:0]             pop_data_o,
    output logic [N_CLIENTS-1:0]          pop_data_valid_o,
    input  logic                          flush_i,
    output logic                          flush_busy_o,
    output logic                          lifo_wrreq_o,
    output logic [DWIDTH-1:0]             lifo_data_o,
    output logic                          lifo_rdreq_o,
    input  logic [DWIDTH-1:0]             lifo_q_i,
    input  logic                          lifo_empty_i,
    input  logic                          lifo_full_i
);

    localparam int CW = client_w(N_CLIENTS);

    if (N_CLIENTS < 2 || AWIDTH < 1) begin : g_bad_param
        $error("lifo_client_arbiter: N_CLIENTS must be >= 2 and AWIDTH >= 1");
    end

    arb_state_t           state;
    logic [CW-1:0]        rr_ptr;
    logic [CW-1:0]        next_ptr;
    logic [N_CLIENTS-1:0] pend_pop;
    logic [N_CLIENTS-1:0] push_elig;
    logic [N_CLIENTS-1:0] pop_elig;
    logic [N_CLIENTS-1:0] req;
    logic [N_CLIENTS-1:0] gnt;
    logic [CW-1:0]        gnt_idx;
    logic                 gnt_any;
    logic                 arb_active;
    logic                 flushing;

    // Gating with rst_i makes reset clear the combinational handshakes immediately.
    assign arb_active = (state == ARB) && !rst_i;
    assign flushing   = (state == FLUSH) && !rst_i;

    assign push_elig = push_valid_i & {N_CLIENTS{~lifo_full_i}};
    assign pop_elig  = pop_valid_i  & {N_CLIENTS{~lifo_empty_i}};
    assign req       = arb_active ? (push_elig | pop_elig) : '0;

    rr_arbiter #(
        .N (N_CLIENTS),
        .W (CW)
    ) u_rr_arbiter (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // A client offering both ops gets the pop.
    assign pop_ready_o  = gnt & pop_elig;
    assign push_ready_o = gnt & push_elig & ~pop_elig;

    assign lifo_wrreq_o     = |push_ready_o;
    assign lifo_rdreq_o     = (|pop_ready_o) || (flushing && !lifo_empty_i);
    assign lifo_data_o      = push_data_i[gnt_idx*DWIDTH +: DWIDTH];
    assign pop_data_o       = lifo_q_i;
    assign pop_data_valid_o = pend_pop;
    assign flush_busy_o     = flushing;

    assign next_ptr = (gnt_idx == CW'(N_CLIENTS - 1)) ? '0 : gnt_idx + CW'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ARB;
            rr_ptr   <= '0;
            pend_pop <= '0;
        end else begin
            pend_pop <= pop_ready_o;
            if (gnt_any) begin
                rr_ptr <= next_ptr;
            end
            case (state)
                ARB:     if (flush_i)      state <= FLUSH;
                FLUSH:   if (lifo_empty_i) state <= ARB;
                default:                   state <= ARB;
            endcase
        end
    end

endmodule
